// File: rtl/axis_rr_arb_if.sv
// rtl/axis_rr_arb_if.sv - stream bundle for the round-robin packet arbiter
// slave is the arbiter's view, master is the sources/sink side.
interface axis_rr_arb_if #(
    parameter int CHANNEL    = 2,
    parameter int DATA_WIDTH = 32
);
    logic [CHANNEL*DATA_WIDTH-1:0] s_axis_tdata;
    logic [CHANNEL-1:0]            s_axis_tvalid;
    logic [CHANNEL-1:0]            s_axis_tready;
    logic [CHANNEL-1:0]            s_axis_tlast;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;
    logic [CHANNEL-1:0]            m_grant;

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        output m_grant
    );

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        input  m_grant
    );
endinterface

// File: rtl/axis_rr_arb.sv
// rtl/axis_rr_arb.sv - packet-level round-robin arbiter and registered mux
// A grant is held from the first beat to the tlast beat; one IDLE cycle arbitrates between packets.
module axis_rr_arb #(
    parameter int CHANNEL    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic          aclk,
    input  logic          aresetn,
    axis_rr_arb_if.slave  bus
);
    localparam int PW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [PW-1:0]           last_q;
    logic [PW-1:0]           gidx_q;
    logic [CHANNEL-1:0]      grant_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    valid_q;
    logic                    tlast_q;

    logic                    win_found;
    logic [PW-1:0]           win_idx;
    logic [CHANNEL-1:0]      win_onehot;
    logic [CHANNEL-1:0]      ready;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_valid;
    logic                    sel_last;
    logic                    accept;
    logic                    take;
    logic                    pkt_end;

    // Output register can take a beat when empty or draining this cycle.
    assign accept  = ~valid_q | bus.m_axis_tready;
    assign take    = (state == BUSY) & sel_valid & accept;
    assign pkt_end = take & sel_last;

    // Search channels above last first, then wrap to the ones at or below it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < CHANNEL; i++) begin
            if (!win_found && bus.s_axis_tvalid[i] && (PW'(i) > last_q)) begin
                win_found = 1'b1;
                win_idx   = PW'(i);
            end
        end
        for (int i = 0; i < CHANNEL; i++) begin
            if (!win_found && bus.s_axis_tvalid[i] && (PW'(i) <= last_q)) begin
                win_found = 1'b1;
                win_idx   = PW'(i);
            end
        end
    end

    assign win_onehot = CHANNEL'(1) << win_idx;

    // Only the granted channel is ever looked at.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < CHANNEL; i++) begin
            if (gidx_q == PW'(i)) begin
                sel_data  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = bus.s_axis_tvalid[i];
                sel_last  = bus.s_axis_tlast[i];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state == BUSY) begin
            ready = grant_q & {CHANNEL{accept}};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (pkt_end) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_q  <= PW'(CHANNEL - 1);
            gidx_q  <= '0;
            grant_q <= '0;
        end else begin
            if ((state == IDLE) && win_found) begin
                gidx_q  <= win_idx;
                grant_q <= win_onehot;
            end
            if (pkt_end) begin
                last_q  <= gidx_q;
                grant_q <= '0;
            end
        end
    end

    // A capture overrides a drain in the same cycle, so valid stays high.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data_q  <= '0;
            tlast_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (take) begin
                data_q  <= sel_data;
                tlast_q <= sel_last;
                valid_q <= 1'b1;
            end else if (bus.m_axis_tready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.s_axis_tready = ready;
    assign bus.m_axis_tdata  = data_q;
    assign bus.m_axis_tvalid = valid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.m_grant       = grant_q;
endmodule
